bouncing_sprite: RTL
====================

# bouncing_sprite

Parametrised bouncing-sprite renderer for the VGA pixel pipeline. It moves a monochrome bitmap sprite across a padded play-field once per frame, with a runtime-programmable speed on each axis, pause, clamped bounces and corner detection. It changes the sprite colour from a 4-entry palette on every bounce. It reads the bitmap from an external synchronous ROM and drives registered 2-bit RGB to the output mux.

## Interface
- H_RES, 640: visible width in pixels
- V_RES, 480: visible height in lines
- SPR_W, 37: sprite width
- SPR_H, 12: sprite height
- PAD, 32: margin kept clear on every screen edge
- START_X, 32: reset X of the sprite's top-left corner; must satisfy PAD ≤ START_X ≤ H_RES-PAD-SPR_W
- START_Y, 32: reset Y of the top-left corner; same rule against V_RES and SPR_H
- SPEED_W, 3: width of the speed inputs
- COL_W = $clog2(SPR_W), ROW_W = $clog2(SPR_H): derived localparams
- clk, in, 1: pixel clock
- rst, in, 1: synchronous, active-high reset
- pix_x, in, 10: current pixel column
- pix_y, in, 10: current pixel line
- frame_tick, in, 1: one-cycle pulse per frame, issued during blanking
- pause, in, 1: 1 freezes motion; rendering continues
- speed_x, in, SPEED_W: pixels moved per frame on X; sampled at frame_tick
- speed_y, in, SPEED_W: pixels moved per frame on Y; sampled at frame_tick
- rom_addr, out, ROW_W+COL_W: {row, col} within the sprite; 0 when the pixel is outside the sprite
- rom_data, in, 1: sprite bit; valid one cycle after rom_addr
- r, out, 2: red
- g, out, 2: green
- b, out, 2: blue
- pos_x, out, 10: current top-left X of the sprite
- pos_y, out, 10: current top-left Y of the sprite
- bounce_count, out, 8: number of frames with a bounce; wraps modulo 256
- corner_hit, out, 1: one-cycle pulse when X and Y bounce in the same frame

## Operation
- State: pos_x, pos_y, dir_x (1 = right), dir_y (1 = down), pal_idx[1:0], bounce_count, corner_hit, and two pixel pipeline stages.
- Reset values:
  - pos_x = START_X, pos_y = START_Y
  - dir_x = dir_y = 1
  - pal_idx = 0, bounce_count = 0, corner_hit = 0
  - pipeline stages cleared, so r/g/b = 0
- Motion is updated only on cycles where frame_tick=1 and pause=0. X and Y are evaluated independently:
  - Moving right: if pos_x+speed_x ≥ H_RES-PAD-SPR_W, set pos_x = H_RES-PAD-SPR_W, set dir_x = 0, and flag bx. Otherwise pos_x += speed_x.
  - Moving left: if pos_x ≤ PAD+speed_x, set pos_x = PAD, set dir_x = 1, and flag bx. Otherwise pos_x -= speed_x.
  - Y follows the same rule with V_RES, SPR_H, speed_y, dir_y, and flag by.
  - Comparisons are done at 11 bits, so there is no wrap-around.
  - speed = 0 on an axis: position is held and no bounce is flagged. This applies even when the sprite sits on the limit.
- Bounce bookkeeping, on the update cycle:
  - If bx|by: bounce_count += 1 and pal_idx += 1.
  - corner_hit = bx&by for exactly that one cycle; it is 0 on all other cycles.
- Palette, as {r,g,b}:
  - 0: {11,11,00} yellow
  - 1: {00,11,11} cyan
  - 2: {11,00,11} magenta
  - 3: {11,11,11} white
  - Background is {00,00,00}.
- Pixel path:
  - in_spr = pos_x ≤ pix_x < pos_x+SPR_W and pos_y ≤ pix_y < pos_y+SPR_H.
  - rom_addr = {pix_y-pos_y, pix_x-pos_x} when in_spr, else 0.
  - Output colour = palette[pal_idx] when the delayed in_spr=1 and rom_data=1; otherwise background.
- frame_tick while pause=1: no motion, no counters change, corner_hit stays 0.
- rst takes priority over frame_tick in the same cycle.

## Timing
- rom_addr is combinational from pix_x, pix_y and the current position.
- Stage 1, at cycle N+1: registers in_spr and palette colour; rom_data arrives in this cycle.
- Stage 2: registers r/g/b. Pixel presented at cycle N appears on r/g/b at cycle N+2 (fixed 2-cycle latency).
- Position, palette and counter outputs change in the cycle after the frame_tick edge. They are stable for the whole visible frame.
- Pipeline stages capture pal_idx at stage 1, so a mid-line change cannot split a pixel.
- Reset asserted mid-frame: by the next cycle all state returns to reset values and r/g/b = 0. Rendering resumes 2 cycles after rst is deasserted.

## Test plan
- Reset with default parameters, then 1 frame_tick with speed 1/1 -> pos_x=33, pos_y=33, bounce_count=0, corner_hit=0.
- Start at x=569, speed_x=3, moving right, 1 tick -> pos_x=571 (clamped), dir_x=0, bounce_count=1, pal_idx=1, r/g/b = cyan for a set bit.
- START_X=571, START_Y=436, speeds 2/2, 1 tick -> pos=(571,436), corner_hit high for exactly 1 cycle, bounce_count=1.
- pause=1 with 5 frame_ticks, speed 4/4 -> position and counters unchanged, corner_hit never asserted.
- Pixel at (pos_x+2, pos_y+1) with ROM returning 1, palette 0 -> rom_addr={1,2}; r/g/b = {11,11,00} exactly 2 cycles later. Pixel outside the sprite -> rom_addr=0 and output 0.
- Assert rst mid-frame after 300 ticks -> next cycle pos=(32,32), bounce_count=0, r/g/b=0; speed_x=0 then holds pos_x across ticks with no bounce.

Source files
------------

// File: rtl/bouncing_sprite.sv
// bouncing_sprite: moves a monochrome ROM bitmap around a padded play-field
// once per frame, bouncing off the margins, cycling a 4-colour palette on
// every bounce, and rendering through a fixed 2-cycle pixel pipeline.
module bouncing_sprite #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int SPR_W   = 37,
    parameter int SPR_H   = 12,
    parameter int PAD     = 32,
    parameter int START_X = 32,
    parameter int START_Y = 32,
    parameter int SPEED_W = 3,
    localparam int COL_W  = $clog2(SPR_W),
    localparam int ROW_W  = $clog2(SPR_H)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic                   frame_tick,
    input  logic                   pause,
    input  logic [SPEED_W-1:0]     speed_x,
    input  logic [SPEED_W-1:0]     speed_y,
    output logic [ROW_W+COL_W-1:0] rom_addr,
    input  logic                   rom_data,
    output logic [1:0]             r,
    output logic [1:0]             g,
    output logic [1:0]             b,
    output logic [9:0]             pos_x,
    output logic [9:0]             pos_y,
    output logic [7:0]             bounce_count,
    output logic                   corner_hit
);

    localparam int ADDR_W = ROW_W + COL_W;

    // Travel limits of the top-left corner, kept at 11 bits so the
    // position+speed sums never wrap.
    localparam logic [10:0] X_LO = 11'(PAD);
    localparam logic [10:0] X_HI = 11'(H_RES - PAD - SPR_W);
    localparam logic [10:0] Y_LO = 11'(PAD);
    localparam logic [10:0] Y_HI = 11'(V_RES - PAD - SPR_H);

    localparam logic [9:0]  X_START = 10'(START_X);
    localparam logic [9:0]  Y_START = 10'(START_Y);

    localparam logic [5:0]  RGB_BLACK = 6'b00_00_00;

    // Palette lookup, packed as {r, g, b}.
    function automatic logic [5:0] palette_rgb(input logic [1:0] idx);
        logic [5:0] rgb;
        case (idx)
            2'd0:    rgb = 6'b11_11_00; // yellow
            2'd1:    rgb = 6'b00_11_11; // cyan
            2'd2:    rgb = 6'b11_00_11; // magenta
            2'd3:    rgb = 6'b11_11_11; // white
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

    // One axis of motion for one frame. Result is {bounce, dir, pos}.
    // A zero speed holds the sprite even when it sits exactly on a limit,
    // so a parked sprite never generates phantom bounces.
    function automatic logic [11:0] axis_step(
        input logic [9:0]         pos,
        input logic               dir,
        input logic [SPEED_W-1:0] spd,
        input logic [10:0]        lo,
        input logic [10:0]        hi
    );
        logic [11:0] res;
        if (spd == {SPEED_W{1'b0}}) begin
            res = {1'b0, dir, pos};
        end else if (dir) begin
            if (({1'b0, pos} + 11'(spd)) >= hi) begin
                res = {1'b1, 1'b0, hi[9:0]};
            end else begin
                res = {1'b0, 1'b1, pos + 10'(spd)};
            end
        end else begin
            if ({1'b0, pos} <= (lo + 11'(spd))) begin
                res = {1'b1, 1'b1, lo[9:0]};
            end else begin
                res = {1'b0, 1'b0, pos - 10'(spd)};
            end
        end
        return res;
    endfunction

    // Motion / bookkeeping state
    logic [9:0]  pos_x_r;
    logic [9:0]  pos_y_r;
    logic        dir_x_r;
    logic        dir_y_r;
    logic [1:0]  pal_idx_r;
    logic [7:0]  bounce_count_r;
    logic        corner_hit_r;

    // Next-frame candidates
    logic [11:0] step_x_s;
    logic [11:0] step_y_s;
    logic        bx_s;
    logic        by_s;
    logic        update_s;

    // Pixel path
    logic [10:0] off_x_s;
    logic [10:0] off_y_s;
    logic        in_spr_s;
    logic        s1_in_spr_r;
    logic [5:0]  s1_rgb_r;
    logic [5:0]  rgb_nxt_s;
    logic [5:0]  rgb_r;

    // Evaluate both axes independently for the next frame update.
    always_comb begin
        step_x_s = axis_step(pos_x_r, dir_x_r, speed_x, X_LO, X_HI);
        step_y_s = axis_step(pos_y_r, dir_y_r, speed_y, Y_LO, Y_HI);
        bx_s     = step_x_s[11];
        by_s     = step_y_s[11];
        update_s = frame_tick & ~pause;
    end

    // Frame-rate motion, palette advance, bounce counter and corner pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x_r        <= X_START;
            pos_y_r        <= Y_START;
            dir_x_r        <= 1'b1;
            dir_y_r        <= 1'b1;
            pal_idx_r      <= 2'd0;
            bounce_count_r <= 8'd0;
            corner_hit_r   <= 1'b0;
        end else if (update_s) begin
            pos_x_r      <= step_x_s[9:0];
            dir_x_r      <= step_x_s[10];
            pos_y_r      <= step_y_s[9:0];
            dir_y_r      <= step_y_s[10];
            corner_hit_r <= bx_s & by_s;
            if (bx_s | by_s) begin
                bounce_count_r <= bounce_count_r + 8'd1;
                pal_idx_r      <= pal_idx_r + 2'd1;
            end
        end else begin
            corner_hit_r <= 1'b0;
        end
    end

    // Sprite hit test and ROM address; offsets are only meaningful (and
    // only used) when the pixel lies at or beyond the top-left corner.
    always_comb begin
        off_x_s  = {1'b0, pix_x} - {1'b0, pos_x_r};
        off_y_s  = {1'b0, pix_y} - {1'b0, pos_y_r};
        in_spr_s = (pix_x >= pos_x_r) && (off_x_s < 11'(SPR_W)) &&
                   (pix_y >= pos_y_r) && (off_y_s < 11'(SPR_H));
        if (in_spr_s) begin
            rom_addr = {off_y_s[ROW_W-1:0], off_x_s[COL_W-1:0]};
        end else begin
            rom_addr = {ADDR_W{1'b0}};
        end
    end

    // Stage 1: capture hit flag and colour while the ROM fetches the bit,
    // so a palette change between frames cannot split a pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_in_spr_r <= 1'b0;
            s1_rgb_r    <= RGB_BLACK;
        end else begin
            s1_in_spr_r <= in_spr_s;
            s1_rgb_r    <= palette_rgb(pal_idx_r);
        end
    end

    // Combine the delayed hit flag with the ROM bit.
    always_comb begin
        if (s1_in_spr_r && rom_data) begin
            rgb_nxt_s = s1_rgb_r;
        end else begin
            rgb_nxt_s = RGB_BLACK;
        end
    end

    // Stage 2: registered colour output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r <= RGB_BLACK;
        end else begin
            rgb_r <= rgb_nxt_s;
        end
    end

    assign r            = rgb_r[5:4];
    assign g            = rgb_r[3:2];
    assign b            = rgb_r[1:0];
    assign pos_x        = pos_x_r;
    assign pos_y        = pos_y_r;
    assign bounce_count = bounce_count_r;
    assign corner_hit   = corner_hit_r;

endmodule
